// File: rtl/uart_boot_loader.sv
// Boot loader: receives an 8N1 UART image (A5, LEN, payload, CHK), writes it word by word
// over a Wishbone classic master port, and releases the core reset once the checksum matches.
module uart_boot_loader #(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          MAX_WORDS    = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_uart_rx,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   input  logic        i_wb_ack,
   output logic        o_core_rst_n,
   output logic        o_boot_done,
   output logic        o_boot_err
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int IW = $clog2(MAX_WORDS + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      M_WAIT_MAGIC, M_LEN_LO, M_LEN_HI, M_DATA, M_WRITE, M_CHECK, M_DONE, M_ERR
   } m_state_t;

   rx_state_t     rx_state_q;
   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0]    rx_bit_q;
   logic [7:0]    rx_shift_q;
   logic [7:0]    byte_q;
   logic          byte_valid_q, frame_err_q;

   // Receiver: bits are sampled at their centres, timed from the start-bit midpoint.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q   <= RX_IDLE;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_s1_q      <= i_uart_rx;
         rx_s2_q      <= rx_s1_q;
         rx_prev_q    <= rx_s2_q;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_s2_q) begin
                  rx_state_q <= RX_START;
                  rx_cnt_q   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt_q == HALF_M1) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CW'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == FULL_M1) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                  else                  rx_bit_q   <= rx_bit_q + 3'd1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CW'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == FULL_M1) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RX_IDLE;
                  if (rx_s2_q) begin
                     byte_valid_q <= 1'b1;
                     byte_q       <= rx_shift_q;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + CW'(1);
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   m_state_t      state_q;
   logic [7:0]    len_lo_q;
   logic [IW-1:0] len_q, idx_q;
   logic [1:0]    bcnt_q;
   logic [31:0]   word_q;
   logic [7:0]    chk_q;

   logic [15:0]   len_d;
   logic          len_bad_d;
   logic [IW-1:0] idx_d;
   logic [31:0]   word_d;

   assign len_d     = {byte_q, len_lo_q};
   assign len_bad_d = (len_d == 16'd0) || ({16'd0, len_d} > $unsigned(MAX_WORDS));
   assign idx_d     = idx_q + IW'(1);
   assign word_d    = {byte_q, word_q[31:8]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= M_WAIT_MAGIC;
         len_lo_q     <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         bcnt_q       <= '0;
         word_q       <= '0;
         chk_q        <= '0;
         o_wb_adr     <= '0;
         o_wb_dat     <= '0;
         o_wb_sel     <= '0;
         o_wb_we      <= 1'b0;
         o_wb_cyc     <= 1'b0;
         o_wb_stb     <= 1'b0;
         o_core_rst_n <= 1'b0;
         o_boot_done  <= 1'b0;
         o_boot_err   <= 1'b0;
      end else if (frame_err_q && state_q != M_DONE) begin
         state_q    <= M_ERR;
         o_boot_err <= 1'b1;
         o_wb_cyc   <= 1'b0;
         o_wb_stb   <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_sel   <= '0;
      end else begin
         case (state_q)
            M_WAIT_MAGIC, M_ERR: begin
               if (byte_valid_q && byte_q == 8'hA5) begin
                  state_q    <= M_LEN_LO;
                  o_boot_err <= 1'b0;
                  chk_q      <= '0;
                  idx_q      <= '0;
                  bcnt_q     <= '0;
               end
            end
            M_LEN_LO: begin
               if (byte_valid_q) begin
                  len_lo_q <= byte_q;
                  state_q  <= M_LEN_HI;
               end
            end
            M_LEN_HI: begin
               if (byte_valid_q) begin
                  if (len_bad_d) begin
                     state_q    <= M_ERR;
                     o_boot_err <= 1'b1;
                  end else begin
                     len_q   <= IW'(len_d);
                     state_q <= M_DATA;
                  end
               end
            end
            M_DATA: begin
               if (byte_valid_q) begin
                  word_q <= word_d;
                  chk_q  <= chk_q + byte_q;
                  bcnt_q <= bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3) begin
                     state_q  <= M_WRITE;
                     o_wb_adr <= BASE_ADDR + 32'({idx_q, 2'b00});
                     o_wb_dat <= word_d;
                     o_wb_sel <= 4'hF;
                     o_wb_we  <= 1'b1;
                     o_wb_cyc <= 1'b1;
                     o_wb_stb <= 1'b1;
                  end
               end
            end
            M_WRITE: begin
               // A new byte before the ack means the slave is too slow: abandon the cycle.
               if (byte_valid_q || i_wb_ack) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  o_wb_we  <= 1'b0;
                  o_wb_sel <= '0;
               end
               if (byte_valid_q) begin
                  state_q    <= M_ERR;
                  o_boot_err <= 1'b1;
               end else if (i_wb_ack) begin
                  idx_q   <= idx_d;
                  state_q <= (idx_d == len_q) ? M_CHECK : M_DATA;
               end
            end
            M_CHECK: begin
               if (byte_valid_q) begin
                  if (byte_q == chk_q) begin
                     state_q      <= M_DONE;
                     o_boot_done  <= 1'b1;
                     o_core_rst_n <= 1'b1;
                  end else begin
                     state_q    <= M_ERR;
                     o_boot_err <= 1'b1;
                  end
               end
            end
            M_DONE: ;
            default: state_q <= M_WAIT_MAGIC;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: UART byte driver, Wishbone slave with programmable ack
// latency, and per-scenario tasks comparing bus writes and status flags to hand-computed values.
module tb_uart_boot_loader;
   localparam int CPB  = 8;
   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx = 1'b1;
   logic        ack = 1'b0;
   logic [31:0] wb_adr, wb_dat;
   logic [3:0]  wb_sel;
   logic        wb_we, wb_cyc, wb_stb;
   logic        core_rst_n, boot_done, boot_err;

   int errors = 0;
   int checks = 0;

   int          ack_delay = 0;
   bit          ack_block = 1'b0;
   int          wcnt = 0;
   int          cyc_seen = 0;
   int          cyc_len = 0;
   int          last_cyc_len = 0;
   bit          unstable = 1'b0;
   logic [31:0] adr0, dat0;
   logic [63:0] wr_q[$];
   logic [7:0]  tx_q[$];

   always #5 clk = ~clk;

   uart_boot_loader #(
      .CLKS_PER_BIT(CPB),
      .BASE_ADDR   (32'h0000_0000),
      .MAX_WORDS   (MAXW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_uart_rx   (rx),
      .o_wb_adr    (wb_adr),
      .o_wb_dat    (wb_dat),
      .o_wb_sel    (wb_sel),
      .o_wb_we     (wb_we),
      .o_wb_cyc    (wb_cyc),
      .o_wb_stb    (wb_stb),
      .i_wb_ack    (ack),
      .o_core_rst_n(core_rst_n),
      .o_boot_done (boot_done),
      .o_boot_err  (boot_err)
   );

   // Wishbone slave: acks after ack_delay wait cycles and logs each committed write.
   always @(negedge clk) begin
      if (wb_cyc && wb_stb) begin
         cyc_seen++;
         if (cyc_len == 0) begin
            adr0 = wb_adr;
            dat0 = wb_dat;
         end else if (wb_adr !== adr0 || wb_dat !== dat0) begin
            unstable = 1'b1;
         end
         cyc_len++;
         if (!ack_block && wcnt >= ack_delay) begin
            ack = 1'b1;
            wcnt = 0;
            wr_q.push_back({wb_adr, wb_dat});
         end else begin
            ack = 1'b0;
            wcnt++;
         end
      end else begin
         ack = 1'b0;
         wcnt = 0;
         if (cyc_len != 0) last_cyc_len = cyc_len;
         cyc_len = 0;
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      @(negedge clk);
      rx = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(CPB);
      end
      rx = stop_ok;
      wait_clks(CPB);
      if (!stop_ok) begin
         rx = 1'b1;
         wait_clks(CPB);
      end
   endtask

   task automatic send_queue();
      while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
   endtask

   task automatic apply_reset();
      reset_n   = 1'b0;
      rx        = 1'b1;
      ack_delay = 0;
      ack_block = 1'b0;
      wait_clks(3);
      reset_n = 1'b1;
      wr_q.delete();
      cyc_seen = 0;
      unstable = 1'b0;
      last_cyc_len = 0;
      wait_clks(3);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      wait_clks(2);
      checks++;
      if ({wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb} !== 71'd0) begin
         errors++;
         $display("FAIL reset_bus: got %h expected 0", {wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb});
      end
      checks++;
      if ({core_rst_n, boot_done, boot_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000", {core_rst_n, boot_done, boot_err});
      end
      apply_reset();
      checks++;
      if ({wb_cyc, core_rst_n, boot_done, boot_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release: got %b expected 0000", {wb_cyc, core_rst_n, boot_done, boot_err});
      end
   endtask

   task automatic test_load_two();
      logic [63:0] w;
      apply_reset();
      tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
      send_queue();
      wait_clks(5);
      checks++;
      if (wr_q.size() !== 2) begin
         errors++;
         $display("FAIL load_count: got %0d expected 2", wr_q.size());
      end
      w = (wr_q.size() > 0) ? wr_q[0] : 64'hDEAD;
      checks++;
      if (w !== {32'h0, 32'h0000_0013}) begin
         errors++;
         $display("FAIL load_w0: got %h expected %h", w, {32'h0, 32'h0000_0013});
      end
      w = (wr_q.size() > 1) ? wr_q[1] : 64'hDEAD;
      checks++;
      if (w !== {32'h4, 32'h0010_0093}) begin
         errors++;
         $display("FAIL load_w1: got %h expected %h", w, {32'h4, 32'h0010_0093});
      end
      checks++;
      if (last_cyc_len !== 1) begin
         errors++;
         $display("FAIL load_zero_wait_len: got %0d expected 1", last_cyc_len);
      end
      checks++;
      if ({core_rst_n, boot_done, boot_err} !== 3'b110) begin
         errors++;
         $display("FAIL load_flags: got %b expected 110", {core_rst_n, boot_done, boot_err});
      end
      send_byte(8'hA5, 1'b1);
      wait_clks(3);
      checks++;
      if ({core_rst_n, boot_done, boot_err} !== 3'b110) begin
         errors++;
         $display("FAIL done_sticky: got %b expected 110", {core_rst_n, boot_done, boot_err});
      end
   endtask

   task automatic test_bad_checksum();
      logic [63:0] w;
      apply_reset();
      tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
      send_queue();
      wait_clks(5);
      checks++;
      if (wr_q.size() !== 2) begin
         errors++;
         $display("FAIL badchk_count: got %0d expected 2", wr_q.size());
      end
      checks++;
      if ({core_rst_n, boot_done, boot_err} !== 3'b001) begin
         errors++;
         $display("FAIL badchk_flags: got %b expected 001", {core_rst_n, boot_done, boot_err});
      end
      send_byte(8'hA5, 1'b1);
      checks++;
      if (boot_err !== 1'b0) begin
         errors++;
         $display("FAIL badchk_err_clear: got %b expected 0", boot_err);
      end
      tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
      send_queue();
      wait_clks(5);
      w = (wr_q.size() > 3) ? wr_q[3] : 64'hDEAD;
      checks++;
      if (w !== {32'h4, 32'h0010_0093}) begin
         errors++;
         $display("FAIL retry_w1: got %h expected %h", w, {32'h4, 32'h0010_0093});
      end
      checks++;
      if ({core_rst_n, boot_done, boot_err} !== 3'b110) begin
         errors++;
         $display("FAIL retry_flags: got %b expected 110", {core_rst_n, boot_done, boot_err});
      end
   endtask

   task automatic test_bad_len();
      apply_reset();
      tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
      send_queue();
      wait_clks(3);
      checks++;
      if ({boot_err, core_rst_n} !== 2'b10) begin
         errors++;
         $display("FAIL len_zero: got %b expected 10", {boot_err, core_rst_n});
      end
      send_byte(8'hA5, 1'b1);
      checks++;
      if (boot_err !== 1'b0) begin
         errors++;
         $display("FAIL len_err_clear: got %b expected 0", boot_err);
      end
      send_byte(8'h05, 1'b1);
      send_byte(8'h00, 1'b1);
      wait_clks(3);
      checks++;
      if ({boot_err, core_rst_n, boot_done} !== 3'b100) begin
         errors++;
         $display("FAIL len_over_max: got %b expected 100", {boot_err, core_rst_n, boot_done});
      end
      checks++;
      if (cyc_seen !== 0) begin
         errors++;
         $display("FAIL len_no_bus: got %0d expected 0", cyc_seen);
      end
   endtask

   task automatic test_glitch();
      logic [63:0] w;
      apply_reset();
      tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11};
      send_queue();
      rx = 1'b0;
      wait_clks(2);
      rx = 1'b1;
      wait_clks(2 * CPB);
      tx_q = '{8'h22, 8'h33, 8'h44, 8'hAA};
      send_queue();
      wait_clks(5);
      w = (wr_q.size() > 0) ? wr_q[0] : 64'hDEAD;
      checks++;
      if (w !== {32'h0, 32'h4433_2211} || wr_q.size() !== 1) begin
         errors++;
         $display("FAIL glitch_word: got %h (n=%0d) expected %h (n=1)", w, wr_q.size(), {32'h0, 32'h4433_2211});
      end
      checks++;
      if ({core_rst_n, boot_done, boot_err} !== 3'b110) begin
         errors++;
         $display("FAIL glitch_flags: got %b expected 110", {core_rst_n, boot_done, boot_err});
      end
      apply_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b0);
      wait_clks(2);
      checks++;
      if ({boot_err, boot_done, core_rst_n} !== 3'b100) begin
         errors++;
         $display("FAIL frame_err: got %b expected 100", {boot_err, boot_done, core_rst_n});
      end
   endtask

   task automatic test_ack_delay();
      logic [63:0] w;
      apply_reset();
      ack_delay = 3;
      tx_q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
      send_queue();
      wait_clks(5);
      checks++;
      if (last_cyc_len !== 4 || unstable !== 1'b0) begin
         errors++;
         $display("FAIL ack_delay_hold: got len=%0d unstable=%0d expected len=4 unstable=0", last_cyc_len, unstable);
      end
      w = (wr_q.size() > 0) ? wr_q[0] : 64'hDEAD;
      checks++;
      if (w !== {32'h0, 32'h1234_5678}) begin
         errors++;
         $display("FAIL ack_delay_word: got %h expected %h", w, {32'h0, 32'h1234_5678});
      end
      checks++;
      if ({core_rst_n, boot_done, boot_err} !== 3'b110) begin
         errors++;
         $display("FAIL ack_delay_flags: got %b expected 110", {core_rst_n, boot_done, boot_err});
      end
   endtask

   task automatic test_overrun();
      apply_reset();
      ack_block = 1'b1;
      tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      send_queue();
      wait_clks(3);
      checks++;
      if ({wb_cyc, wb_stb, wb_we, wb_sel} !== 7'b111_1111) begin
         errors++;
         $display("FAIL overrun_open: got %b expected 1111111", {wb_cyc, wb_stb, wb_we, wb_sel});
      end
      send_byte(8'h05, 1'b1);
      wait_clks(2);
      checks++;
      if ({boot_err, wb_cyc, wb_stb} !== 3'b100) begin
         errors++;
         $display("FAIL overrun_err: got %b expected 100", {boot_err, wb_cyc, wb_stb});
      end
      checks++;
      if (wr_q.size() !== 0) begin
         errors++;
         $display("FAIL overrun_no_write: got %0d expected 0", wr_q.size());
      end
      ack_block = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [63:0] w;
      apply_reset();
      tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
      send_queue();
      checks++;
      if (wr_q.size() !== 1) begin
         errors++;
         $display("FAIL mid_first_write: got %0d expected 1", wr_q.size());
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb, core_rst_n, boot_done, boot_err} !== 74'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h expected 0",
                  {wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb, core_rst_n, boot_done, boot_err});
      end
      apply_reset();
      tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
      send_queue();
      wait_clks(5);
      w = (wr_q.size() > 0) ? wr_q[0] : 64'hDEAD;
      checks++;
      if (w !== {32'h0, 32'h0000_0013}) begin
         errors++;
         $display("FAIL mid_reload_w0: got %h expected %h", w, {32'h0, 32'h0000_0013});
      end
      checks++;
      if ({core_rst_n, boot_done, boot_err} !== 3'b110 || wr_q.size() !== 2) begin
         errors++;
         $display("FAIL mid_reload_done: got flags=%b n=%0d expected flags=110 n=2",
                  {core_rst_n, boot_done, boot_err}, wr_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_load_two();
      test_bad_checksum();
      test_bad_len();
      test_glitch();
      test_ack_delay();
      test_overrun();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Boot loader that sits upstream of the instruction memory in `rv32i_soc` and brings up the core. It receives a program image over the UART RX pin (8N1), checks it, and writes it word-by-word into instruction memory through a Wishbone classic master port. The core is held in reset until the whole image has been loaded and its checksum has passed.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200).
- `BASE_ADDR`, default 32'h0000_0000: byte address where word 0 is written.
- `MAX_WORDS`, default 4096: largest word count that is accepted.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `i_uart_rx`  in  1  serial input; asynchronous, idle high.
- `o_wb_adr`  out  32  Wishbone byte address.
- `o_wb_dat`  out  32  Wishbone write data.
- `o_wb_sel`  out  4  byte select; always 4'hF during a cycle.
- `o_wb_we`  out  1  write enable.
- `o_wb_cyc`  out  1  bus cycle.
- `o_wb_stb`  out  1  strobe.
- `i_wb_ack`  in  1  slave acknowledge.
- `o_core_rst_n`  out  1  reset to the core, active-low.
- `o_boot_done`  out  1  image loaded and verified; sticky.
- `o_boot_err`  out  1  last load attempt failed.

## Operation
- Reset values: every `o_wb_*` output is 0, `o_core_rst_n`=0, `o_boot_done`=0, `o_boot_err`=0. Both the receiver and the main FSM go idle.
- RX front end:
  - `i_uart_rx` passes through a 2-flop synchronizer.
  - A falling edge starts a frame. The line is sampled at CLKS_PER_BIT/2; if it is high there, the start is false and is dropped.
  - The 8 data bits are then sampled LSB first, CLKS_PER_BIT apart, followed by the stop bit.
  - Stop bit = 1: raise a one-cycle `byte_valid` with the byte.
  - Stop bit = 0: framing error.
- Frame format, all multi-byte fields little-endian:
  - magic 0xA5
  - LEN_LO, LEN_HI (word count N)
  - N×4 payload bytes
  - CHK = (sum of payload bytes) mod 256
- FSM states: WAIT_MAGIC, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR.
- WAIT_MAGIC: bytes other than 0xA5 are ignored. 0xA5 clears `o_boot_err`, clears the checksum and word index, and moves to LEN_LO.
- LEN_LO → LEN_HI → N is evaluated. N==0 or N>MAX_WORDS → ERR; otherwise → DATA.
- DATA: bytes are shifted into a 32-bit word register (first byte goes to [7:0]) and added to the checksum. After the 4th byte → WRITE.
- WRITE: issue one Wishbone write of the word to BASE_ADDR + 4×index. On `i_wb_ack`, increment index; index==N → CHECK, else → DATA.
- CHECK: next byte == checksum → DONE; otherwise → ERR.
- DONE: `o_boot_done`=1 and `o_core_rst_n`=1. Further UART input is ignored; only `reset_n` leaves this state.
- ERR: `o_boot_err`=1 and the core stays in reset. Bytes are ignored until 0xA5, which restarts the load as in WAIT_MAGIC. Words already written are not rolled back.
- A framing error in any state other than DONE → ERR.
- A `byte_valid` that arrives while in WRITE (ack not yet received) is an overrun → ERR. Any open bus cycle is dropped the same cycle.
- Index width: clog2(MAX_WORDS+1). Address arithmetic is 32-bit and wraps without any check.

## Timing
- `byte_valid` fires at the stop-bit mid-sample. That is about 9.5×CLKS_PER_BIT + 2 cycles after the start edge, including synchronizer delay.
- `o_wb_cyc`, `o_wb_stb` and `o_wb_we` assert the cycle after the 4th data byte's `byte_valid`. They, together with `o_wb_adr`/`o_wb_dat`, hold steady until the cycle in which `i_wb_ack` is sampled high, and deassert the cycle after it.
- Zero-wait acks are allowed. There is no timeout; a slave that never acks stalls the load until an overrun occurs.
- `o_core_rst_n` and `o_boot_done` rise the cycle after the matching CHK `byte_valid`.
- `o_boot_err` rises the cycle after the error event. It clears the cycle after a 0xA5 `byte_valid`.
- Asserting `reset_n` in the middle of a load aborts immediately: outputs return to their reset values and the bus cycle drops asynchronously.

## Test plan
- Load two words. Send A5 02 00 13 00 00 00 93 00 10 00 B6 → Wishbone writes (0x0, 0x00000013) then (0x4, 0x00100093), `o_boot_done`=1, `o_core_rst_n`=1, `o_boot_err`=0.
- Bad checksum. Same frame with CHK=B7 → both writes occur, `o_boot_err`=1, `o_core_rst_n`=0. Then resend the correct frame → done, with err cleared at the 0xA5.
- Noise before magic and bad length. Bytes 00 FF A5 00 00 → ERR on N=0. Then A5 with N=MAX_WORDS+1 → ERR and no bus cycles.
- Line glitches. A low pulse shorter than CLKS_PER_BIT/2 → no byte received. A stop bit forced to 0 during LEN_LO → `o_boot_err`=1.
- Ack and overrun. Delay `i_wb_ack` by 3 cycles → `o_wb_adr`/`o_wb_dat` stay stable for 4 cycles. Withhold ack until the next byte arrives → ERR, cyc drops.
- Reset mid-load. Pulse `reset_n` low after 5 payload bytes → all outputs 0. A fresh full frame afterwards loads correctly from index 0.
